whack_score_keeper: RTL
=======================

// Module: whack_score_keeper
// PURPOSE
//  Score and round controller downstream of the whack-a-mole core.
//  - Consumes the core's per-mole lamp lines, button rising-edge pulses and hit pulse.
//  - Keeps a 2-digit BCD score and counts mole appearances.
//  - Ends the game after a fixed number of moles.
//  - Drives one time-multiplexed 7-segment digit onto the TinyTapeout outputs.
// PARAMETERS
//  MAX_MOLES    20    mole appearances per game (1..255)
//  DIGIT_TICKS  8     clk cycles each digit (tens/units) is shown before toggling (>=1)
// PORTS
//  clk          in   1  single clock; all flops on rising edge
//  rst_n        in   1  synchronous reset, active low
//  start_i      in   1  1-cycle pulse: start/restart a game
//  mole_i       in   3  lamp lines from the core; one-hot or zero
//  btn_rise_i   in   3  1-cycle button rising-edge pulses from the core
//  hit_i        in   1  1-cycle hit pulse from the core
//  seg_o        out  7  {g,f,e,d,c,b,a}, active high
//  dp_o         out  1  1 while the tens digit is displayed
//  game_over_o  out  1  1 in OVER state
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - state=IDLE, score=00, mole_cnt=0, digit_sel=units, tick=0.
//   - Outputs: seg_o=7'b0111111 ("0"), dp_o=0, game_over_o=0.
//   - Reset overrides every other input, including mid-game.
//  New-mole event: mole_i != mole_q (mole_i registered last cycle) and mole_i != 0.
//   - mole_q resets to 0.
//  FSM IDLE -> PLAY -> OVER:
//   - IDLE: hit_i and mole events are ignored. start_i -> PLAY.
//   - PLAY (entry): score=00, mole_cnt=0, armed=0.
//   - PLAY, each new-mole event:
//     - mole_cnt<MAX_MOLES: mole_cnt+1, armed=1.
//     - mole_cnt==MAX_MOLES: -> OVER; that event's mole is not counted.
//   - PLAY, hit_i while armed=1: BCD score+1, armed=0.
//     - One point per mole; repeat hits are ignored until the next new-mole event.
//     - Score saturates at 99.
//   - PLAY, hit_i while armed=0: ignored.
//   - OVER: score frozen, game_over_o=1, hit_i/btn_rise_i ignored. start_i -> PLAY.
//   - start_i in PLAY restarts: clear score and mole_cnt, stay in PLAY.
//  Timing:
//   - Score, state and game_over_o update on the clk edge that samples the input.
//   - seg_o reflects the new score one cycle later; seg_o/dp_o are registered.
//  Simultaneous events in one cycle:
//   - start_i has priority over all other inputs.
//   - A new-mole event and hit_i together: the hit is scored against the old arm state, then re-arm.
//  Display:
//   - tick counts 0..DIGIT_TICKS-1; on wrap, digit_sel toggles.
//   - Tens digit shown with dp_o=1, units digit with dp_o=0.
//   - Both digits are always shown; a leading zero is displayed.
// CONFIGURATION
//  WHACK_MISS_PENALTY_EN defined:
//   - In PLAY, a btn_rise_i bit set where mole_i is 0 decrements score by 1 (saturates at 00).
//   - If hit_i is in the same cycle, the hit wins and no penalty is applied.
//   - Multiple wrong bits in one cycle cost 1 point.
//  Undefined: btn_rise_i is unused; the score never decreases.
// STRUCTURE
//  whack_pkg:
//   - state_t enum {IDLE, PLAY, OVER}.
//   - SEG_BLANK constant; SEG_DIGIT[0:9] 7-bit pattern table.
//   - bcd_inc / bcd_dec saturating functions.
//  Sub-module seg7_decode: combinational 4-bit BCD -> 7-seg, instantiated once on the muxed digit.
//  All state lives in whack_score_keeper.
// TESTING
//  1. Reset:
//     - rst_n=0 for 2 cycles -> seg_o=7'b0111111, dp_o=0, game_over_o=0.
//     - hit_i pulses in IDLE -> score stays 00.
//  2. start_i; 5 distinct moles, each hit once -> score 05.
//     - Display alternates every 8 cycles: tens "0" (dp_o=1) / units 7'b1101101 (dp_o=0).
//  3. One mole, hit_i pulsed 3x -> score +1 only.
//     - Next mole + hit -> +1 again.
//  4. MAX_MOLES=4:
//     - 5th new mole -> game_over_o=1 next edge; later hits leave score unchanged.
//     - start_i -> game_over_o=0, score 00.
//  5. Score at 99, new mole + hit -> stays 99.
//     - rst_n=0 mid-game -> IDLE, score 00.
//  6. Penalty, mole_i=001:
//     - btn_rise_i=010 at score 03 -> 02 with WHACK_MISS_PENALTY_EN, 03 without.
//     - Same stimulus at score 00 -> stays 00.
//     - btn_rise_i=010 together with hit_i -> score +1.

Source files
------------

// File: rtl/whack_pkg.sv
// whack_pkg: game state type, 7-segment pattern table and saturating 2-digit BCD helpers.
package whack_pkg;
  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v == 8'h99) ? v :
           (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    return (v == 8'h00) ? v :
           (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
  endfunction
endpackage

// File: rtl/whack_score_keeper_seg7_decode.sv
// seg7_decode: combinational BCD digit to {g,f,e,d,c,b,a} segments; non-decimal codes blank.
module seg7_decode
  import whack_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);
  assign seg_o = (bcd_i <= 4'd9) ? SEG_DIGIT[bcd_i] : SEG_BLANK;
endmodule

// File: rtl/whack_score_keeper.sv
// whack_score_keeper: score/round controller with a multiplexed 2-digit 7-segment display.
// Optional WHACK_MISS_PENALTY_EN: a button press on a dark lamp costs one point.
module whack_score_keeper
  import whack_pkg::*;
#(
  parameter int MAX_MOLES   = 20,
  parameter int DIGIT_TICKS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [2:0] mole_i,
  input  logic [2:0] btn_rise_i,
  input  logic       hit_i,
  output logic [6:0] seg_o,
  output logic       dp_o,
  output logic       game_over_o
);
  localparam int TW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam logic [7:0] MAX_CNT = 8'(MAX_MOLES);
  state_t state_q, state_d;
  logic [7:0] score_q, score_d, cnt_q, cnt_d;
  logic [2:0] mole_q;
  logic armed_q, armed_d, sel_q, dp_q, over_q;
  logic [TW-1:0] tick_q;
  logic [6:0] seg_q, seg_w;
  logic new_mole, miss, tick_wrap;
  assign new_mole  = (mole_i != mole_q) && (mole_i != 3'b000);
  assign tick_wrap = tick_q == TW'(DIGIT_TICKS - 1);
`ifdef WHACK_MISS_PENALTY_EN
  assign miss = |(btn_rise_i & ~mole_i);
`else
  logic unused_btn;
  assign unused_btn = ^btn_rise_i;
  assign miss = 1'b0;
`endif
  // The hit is judged against the arm state held before this cycle's new mole re-arms it.
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (start_i) begin
      state_d = PLAY;
      score_d = 8'h00;
      cnt_d   = 8'd0;
      armed_d = 1'b0;
    end else if (state_q == PLAY) begin
      score_d = hit_i ? (armed_q ? bcd_inc(score_q) : score_q) : (miss ? bcd_dec(score_q) : score_q);
      armed_d = armed_q & ~hit_i;
      if (new_mole && cnt_q < MAX_CNT) begin
        cnt_d   = cnt_q + 8'd1;
        armed_d = 1'b1;
      end else if (new_mole) begin
        state_d = OVER;
      end
    end
  end
  seg7_decode u_dec (
    .bcd_i(sel_q ? score_q[7:4] : score_q[3:0]),
    .seg_o(seg_w)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      score_q <= 8'h00;
      cnt_q   <= 8'd0;
      armed_q <= 1'b0;
      mole_q  <= 3'b000;
      over_q  <= 1'b0;
      tick_q  <= '0;
      sel_q   <= 1'b0;
      seg_q   <= SEG_DIGIT[0];
      dp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      mole_q  <= mole_i;
      over_q  <= state_d == OVER;
      tick_q  <= tick_wrap ? '0 : tick_q + 1'b1;
      sel_q   <= sel_q ^ tick_wrap;
      seg_q   <= seg_w;
      dp_q    <= sel_q;
    end
  end
  assign seg_o       = seg_q;
  assign dp_o        = dp_q;
  assign game_over_o = over_q;
endmodule
